// File: rtl/fee_settle.sv
// fee_settle: wash-fee settlement stage with BCD charge/deduct, 7-segment scan display and buzzer
module fee_settle #(
  parameter int SCAN_CYC = 100_000,
  parameter int BEEP_CYC = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        confirm,
  input  logic [1:0]  mode,
  input  logic        overtime,
  input  logic [11:0] bal,
  input  logic [11:0] price0,
  input  logic [11:0] price1,
  input  logic [11:0] price2,
  input  logic [11:0] price3,
  input  logic [11:0] fine,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        buzzer,
  output logic [11:0] new_bal,
  output logic        short,
  output logic        done
);
  localparam int SW = $clog2(SCAN_CYC + 1);
  localparam int BW = $clog2(BEEP_CYC + 1);
  typedef enum logic [2:0] {IDLE, CALC, SHOW, DEDUCT, SHORTFALL, DONE} state_t;
  state_t state, nxt;
  logic [11:0] charge, deficit, price, val;
  logic [SW-1:0] scan_cnt;
  logic [BW-1:0] beep_cnt;
  logic [1:0] dig;
  logic [2:0] ph;
  logic [3:0] nib;
  logic [6:0] letter;
  logic scan_wrap, beep_wrap, abort;

  function automatic logic [11:0] bcd_add(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] s;
    logic [4:0] d;
    logic c;
    c = 1'b0;
    s = '0;
    for (int i = 0; i < 3; i++) begin
      d = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'd0, c};
      c = d > 5'd9;
      s[i*4 +: 4] = c ? 4'(d - 5'd10) : d[3:0];
    end
    return c ? 12'h999 : s;
  endfunction

  function automatic logic [11:0] bcd_sub(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] s;
    logic [4:0] d;
    logic br;
    br = 1'b0;
    s = '0;
    for (int i = 0; i < 3; i++) begin
      d = {1'b0, a[i*4 +: 4]} - {1'b0, b[i*4 +: 4]} - {4'd0, br};
      br = d[4];
      s[i*4 +: 4] = br ? 4'(d + 5'd10) : d[3:0];
    end
    return s;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  assign price = mode == 2'd0 ? price0 : mode == 2'd1 ? price1 : mode == 2'd2 ? price2 : price3;
  assign abort = state != IDLE && !en;
  assign scan_wrap = scan_cnt == SW'(SCAN_CYC - 1);
  assign beep_wrap = beep_cnt == BW'(BEEP_CYC - 1);

  // next-state: dropping en from any active state wins over everything else
  always_comb begin
    nxt = state;
    if (abort) nxt = IDLE;
    else case (state)
      IDLE:      nxt = en ? CALC : IDLE;
      CALC:      nxt = SHOW;
      SHOW:      nxt = confirm ? (bal < charge ? SHORTFALL : DEDUCT) : SHOW;
      DEDUCT:    nxt = DONE;
      SHORTFALL: nxt = confirm ? DONE : SHORTFALL;
      default:   nxt = state;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= nxt;
  end

  // settlement datapath: charge latch, deduction, shortfall deficit and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      charge <= '0;
      deficit <= '0;
      new_bal <= '0;
      short <= 1'b0;
      done <= 1'b0;
    end else if (abort) begin
      short <= 1'b0;
      done <= 1'b0;
    end else begin
      if (state == CALC) charge <= bcd_add(price, overtime ? fine : 12'h000);
      if (state == SHOW && nxt == SHORTFALL) begin
        new_bal <= '0;
        short <= 1'b1;
        deficit <= bcd_sub(charge, bal);
      end
      if (state == DEDUCT) new_bal <= bcd_sub(bal, charge);
      if (state != DONE && nxt == DONE) done <= 1'b1;
    end
  end

  // digit scan: held at the first digit while idle, then advances every SCAN_CYC cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      dig <= '0;
    end else if (state == IDLE) begin
      scan_cnt <= '0;
      dig <= '0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      dig <= dig + 2'd1;
    end else scan_cnt <= scan_cnt + 1'b1;
  end

  // buzzer: free toggling in SHORTFALL, two on/off pairs then silence in DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buzzer <= 1'b0;
      beep_cnt <= '0;
      ph <= '0;
    end else if (abort) begin
      buzzer <= 1'b0;
      beep_cnt <= '0;
      ph <= '0;
    end else if (nxt != state && (nxt == SHORTFALL || nxt == DONE)) begin
      buzzer <= 1'b1;
      beep_cnt <= '0;
      ph <= '0;
    end else if (state == SHORTFALL) begin
      beep_cnt <= beep_wrap ? '0 : beep_cnt + 1'b1;
      if (beep_wrap) buzzer <= ~buzzer;
    end else if (state == DONE && ph != 3'd4) begin
      beep_cnt <= beep_wrap ? '0 : beep_cnt + 1'b1;
      if (beep_wrap) begin
        ph <= ph + 3'd1;
        buzzer <= ph == 3'd1;
      end
    end
  end

  // display: letter on the leftmost digit, BCD value on the other three
  always_comb begin
    val = state == SHOW ? charge : state == DONE ? new_bal : deficit;
    nib = dig == 2'd2 ? val[11:8] : dig == 2'd1 ? val[7:4] : val[3:0];
    letter = state == SHOW ? 7'h39 : state == DONE ? 7'h7C : 7'h79;
    seg = (state == SHOW || state == DONE || state == SHORTFALL) ? {1'b0, dig == 2'd3 ? letter : seg7(nib)} : 8'h00;
    an = state == IDLE ? 4'b0000 : 4'b0001 << dig;
  end
endmodule

// File: tb/tb_fee_settle.sv
// tb_fee_settle: directed settlement scenarios checked every cycle against an arithmetic model
module tb_fee_settle;
  localparam int S = 4;
  localparam int B = 8;
  localparam int P_IDLE = 0, P_CALC = 1, P_SHOW = 2, P_DED = 3, P_SHORT = 4, P_DONE = 5;
  localparam logic [6:0] DIGS [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic clk = 1'b0;
  logic rst, en, confirm, overtime, buzzer, short, done;
  logic [1:0] mode;
  logic [11:0] bal, price0, price1, price2, price3, fine, new_bal;
  logic [7:0] seg;
  logic [3:0] an;
  int n_chk = 0, n_fail = 0;
  int ph, c, t, m_charge, m_new, m_def, m_short, m_done;
  int highs, rises;
  logic prev;

  fee_settle #(.SCAN_CYC(S), .BEEP_CYC(B)) dut (
    .clk(clk), .rst(rst), .en(en), .confirm(confirm), .mode(mode), .overtime(overtime),
    .bal(bal), .price0(price0), .price1(price1), .price2(price2), .price3(price3), .fine(fine),
    .seg(seg), .an(an), .buzzer(buzzer), .new_bal(new_bal), .short(short), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int dec(input logic [11:0] x);
    return int'(x[11:8]) * 100 + int'(x[7:4]) * 10 + int'(x[3:0]);
  endfunction

  function automatic logic [11:0] tobcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_update;
    int p;
    logic [11:0] pr;
    c++;
    t++;
    if (!rst) begin
      ph = P_IDLE;
      m_charge = 0;
      m_new = 0;
      m_def = 0;
      m_short = 0;
      m_done = 0;
    end else if (ph != P_IDLE && !en) begin
      ph = P_IDLE;
      m_done = 0;
      m_short = 0;
    end else case (ph)
      P_IDLE: if (en) begin ph = P_CALC; c = 0; end
      P_CALC: begin
        pr = mode == 0 ? price0 : mode == 1 ? price1 : mode == 2 ? price2 : price3;
        p = dec(pr) + (overtime ? dec(fine) : 0);
        m_charge = p > 999 ? 999 : p;
        ph = P_SHOW;
      end
      P_SHOW: if (confirm) begin
        if (dec(bal) >= m_charge) ph = P_DED;
        else begin
          ph = P_SHORT;
          m_new = 0;
          m_short = 1;
          m_def = m_charge - dec(bal);
          t = 0;
        end
      end
      P_DED: begin m_new = dec(bal) - m_charge; ph = P_DONE; m_done = 1; t = 0; end
      P_SHORT: if (confirm) begin ph = P_DONE; m_done = 1; t = 0; end
      default: ;
    endcase
  endtask

  task automatic compare_all;
    int k, v, div;
    logic [3:0] e_an;
    logic [7:0] e_seg;
    logic e_buz;
    k = (c / S) % 4;
    div = k == 0 ? 1 : k == 1 ? 10 : 100;
    e_an = ph == P_IDLE ? 4'b0000 : 4'(1 << k);
    v = ph == P_SHOW ? m_charge : ph == P_DONE ? m_new : m_def;
    if (ph == P_SHOW || ph == P_DONE || ph == P_SHORT)
      e_seg = k == 3 ? (ph == P_SHOW ? 8'h39 : ph == P_DONE ? 8'h7C : 8'h79) : {1'b0, DIGS[(v / div) % 10]};
    else e_seg = 8'h00;
    e_buz = ph == P_SHORT ? ((t / B) % 2 == 0) : ph == P_DONE ? (t < 4 * B && (t / B) % 2 == 0) : 1'b0;
    check("an", an, e_an);
    check("seg", seg, e_seg);
    check("buzzer", buzzer, e_buz);
    check("done", done, m_done);
    check("short", short, m_short);
    if (m_done != 0) check("new_bal", new_bal, tobcd(m_new));
  endtask

  task automatic step;
    @(posedge clk);
    model_update();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic wait_an(input logic [3:0] x);
    int i;
    i = 0;
    while (an != x && i < 20) begin
      step();
      i++;
    end
    if (an != x) check("wait_an", an, x);
  endtask

  task automatic pulse_confirm;
    confirm = 1'b1;
    step();
    confirm = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; confirm = 1'b0; overtime = 1'b0; mode = 2'd0; bal = '0;
    price0 = '0; price1 = '0; price2 = '0; price3 = '0; fine = '0;
    ph = P_IDLE; c = 0; t = 0; m_charge = 0; m_new = 0; m_def = 0; m_short = 0; m_done = 0;
    #2;
    check("rst_an", an, 4'b0000);
    check("rst_seg", seg, 8'h00);
    check("rst_buzzer", buzzer, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_short", short, 1'b0);
    check("rst_new_bal", new_bal, 12'h000);
    step(); step();
    rst = 1'b1;
    step(); step();

    mode = 2'd2; price2 = 12'h067; bal = 12'h100; en = 1'b1;
    step(); step();
    check("s1_charge_model", m_charge, 67);
    for (int i = 0; i < 16; i++) begin
      step();
      case (an)
        4'b0001: check("s1_units", seg, 8'h07);
        4'b0010: check("s1_tens", seg, 8'h7D);
        4'b0100: check("s1_hund", seg, 8'h3F);
        4'b1000: check("s1_letter", seg, 8'h39);
        default: check("s1_an_onehot", an, 4'b0001);
      endcase
    end
    pulse_confirm();
    prev = buzzer; highs = 0; rises = 0;
    for (int i = 0; i < 45; i++) begin
      step();
      highs += int'(buzzer);
      rises += int'(buzzer && !prev);
      prev = buzzer;
    end
    check("s1_new_bal", new_bal, 12'h033);
    check("s1_short", short, 1'b0);
    check("s1_done", done, 1'b1);
    check("s1_buz_high_cycles", highs, 16);
    check("s1_buz_pulses", rises, 2);
    pulse_confirm();
    step();
    check("s1_done_after_confirm", done, 1'b1);
    en = 1'b0;
    step();
    check("s1_done_cleared", done, 1'b0);
    check("s1_an_idle", an, 4'b0000);

    mode = 2'd3; price3 = 12'h089; fine = 12'h028; overtime = 1'b1; bal = 12'h500; en = 1'b1;
    step(); step();
    overtime = 1'b0; price3 = 12'h000;
    check("s2_charge_model", m_charge, 117);
    wait_an(4'b0100);
    check("s2_hund", seg, 8'h06);
    wait_an(4'b0001);
    check("s2_units", seg, 8'h07);
    pulse_confirm();
    step();
    check("s2_new_bal", new_bal, 12'h383);
    check("s2_done", done, 1'b1);
    en = 1'b0;
    step();

    mode = 2'd0; price0 = 12'h023; bal = 12'h010; en = 1'b1;
    step(); step();
    pulse_confirm();
    check("s3_short", short, 1'b1);
    check("s3_new_bal_zero", new_bal, 12'h000);
    check("s3_buzzer_starts_high", buzzer, 1'b1);
    wait_an(4'b1000);
    check("s3_letter", seg, 8'h79);
    wait_an(4'b0100);
    check("s3_hund", seg, 8'h3F);
    wait_an(4'b0010);
    check("s3_tens", seg, 8'h06);
    wait_an(4'b0001);
    check("s3_units", seg, 8'h4F);
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      highs += int'(buzzer);
    end
    check("s3_buz_duty", highs, 8);
    pulse_confirm();
    check("s3_done", done, 1'b1);
    check("s3_new_bal", new_bal, 12'h000);
    check("s3_short_kept", short, 1'b1);
    en = 1'b0;
    step();

    mode = 2'd1; price1 = 12'h999; fine = 12'h999; overtime = 1'b1; bal = 12'h999; en = 1'b1;
    step(); step();
    check("s4_charge_model", m_charge, 999);
    wait_an(4'b0001);
    check("s4_units", seg, 8'h6F);
    pulse_confirm();
    step();
    check("s4_new_bal", new_bal, 12'h000);
    check("s4_short", short, 1'b0);
    check("s4_done", done, 1'b1);
    en = 1'b0;
    step();

    mode = 2'd2; overtime = 1'b0; bal = 12'h100; en = 1'b1;
    step(); step(); step(); step();
    en = 1'b0; confirm = 1'b1;
    step();
    confirm = 1'b0;
    check("s5_an", an, 4'b0000);
    check("s5_seg", seg, 8'h00);
    check("s5_buzzer", buzzer, 1'b0);
    check("s5_done", done, 1'b0);
    step(); step();

    mode = 2'd0; bal = 12'h010; en = 1'b1;
    step(); step();
    pulse_confirm();
    step(); step();
    rst = 1'b0;
    #1;
    check("s6_an", an, 4'b0000);
    check("s6_seg", seg, 8'h00);
    check("s6_buzzer", buzzer, 1'b0);
    check("s6_short", short, 1'b0);
    check("s6_done", done, 1'b0);
    check("s6_new_bal", new_bal, 12'h000);
    en = 1'b0;
    step();
    rst = 1'b1;
    step(); step();
    check("s6_idle_wait", an, 4'b0000);

    mode = 2'd2; bal = 12'h100; en = 1'b1;
    step(); step();
    pulse_confirm();
    step();
    check("s7_new_bal", new_bal, 12'h033);
    en = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
